dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_array.sv | 30 +++
 rtl/dmem_responder.sv | 122 ++++++++++++
 tb/tb_dmem_responder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states, word geometry,
// default build parameters and the address fault check.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StRespond
  } state_e;

  localparam int unsigned WORD_BYTES      = 8;
  localparam int unsigned OFFSET_BITS     = $clog2(WORD_BYTES);
  localparam int unsigned DEFAULT_DEPTH   = 256;
  localparam int unsigned DEFAULT_LATENCY = 2;
  // Wide enough for LATENCY up to 8.
  localparam int unsigned CNT_W           = 4;

  // Faults on a sub-word offset or any address bit above the word index field.
  function automatic logic addr_fault(input logic [63:0] addr, input int unsigned idx_w);
    logic [63:0] hi;
    hi = addr >> (idx_w + OFFSET_BITS);
    return (addr[OFFSET_BITS-1:0] != '0) || (hi != '0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port 64-bit word store: negedge-synchronous write, registered read.
// Contents are not reset.
module dmem_array import dmem_pkg::*; #(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned IdxW = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            en_i,
  input  logic            we_i,
  input  logic [IdxW-1:0] idx_i,
  input  logic [63:0]     wdata_i,
  output logic [63:0]     rdata_o
);

  logic [63:0] mem_q [DEPTH];
  logic [63:0] rdata_q;

  always_ff @(negedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[idx_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: accepts one access, waits LATENCY edges, then pulses a
// response. All state moves on the falling edge to line up with the pipeline registers.
module dmem_responder import dmem_pkg::*; #(
  parameter int unsigned DEPTH   = DEFAULT_DEPTH,
  parameter int unsigned LATENCY = DEFAULT_LATENCY
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LatLoad = CNT_W'(LATENCY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q;
  logic [63:0]      addr_q, wdata_q;

  logic        accept;
  logic        go_rsp;
  logic        cur_write;
  logic        cur_fault;
  logic [63:0] cur_addr;
  logic [63:0] cur_wdata;
  logic [63:0] arr_rdata;
  logic        in_rsp;
  logic        rsp_fault;

  assign req_ready = !resetl && ((state_q == StIdle) || (state_q == StRespond));
  assign accept    = req_valid && req_ready;

  // With LATENCY=1 the commit happens on the accepting edge, so use the live request.
  assign cur_write = accept ? req_write : wr_q;
  assign cur_addr  = accept ? req_addr  : addr_q;
  assign cur_wdata = accept ? req_wdata : wdata_q;
  assign cur_fault = addr_fault(cur_addr, IdxW);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_rsp  = 1'b0;
    if (resetl) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StRespond: begin
          if (accept) begin
            if (LATENCY == 1) begin
              state_d = StRespond;
              go_rsp  = 1'b1;
            end else begin
              state_d = StAccess;
              cnt_d   = LatLoad;
            end
          end else begin
            state_d = StIdle;
          end
        end
        StAccess: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = StRespond;
            cnt_d   = '0;
            go_rsp  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(negedge CLK) begin
    if (resetl) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk_i  (CLK),
    .en_i   (go_rsp && !cur_fault),
    .we_i   (cur_write),
    .idx_i  (cur_addr[IdxW+OFFSET_BITS-1:OFFSET_BITS]),
    .wdata_i(cur_wdata),
    .rdata_o(arr_rdata)
  );

  assign in_rsp    = (state_q == StRespond);
  assign rsp_fault = addr_fault(addr_q, IdxW);
  assign rsp_valid = in_rsp;
  assign rsp_err   = in_rsp && rsp_fault;
  assign rsp_rdata = (in_rsp && !wr_q && !rsp_fault) ? arr_rdata : '0;
  assign busy      = (state_q == StAccess) || (req_valid && !req_ready);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for the main sequence and a
// LATENCY=1 instance for the single-edge path.
module tb_dmem_responder;

  logic        CLK = 1'b1;
  logic        resetl;
  logic        req_valid, req_write;
  logic [63:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [63:0] rsp_rdata;

  logic        v1, w1;
  logic [63:0] a1, d1;
  logic        ready1, rvalid1, err1, busy1;
  logic [63:0] rdata1;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] model [256];

  always #5 CLK = ~CLK;

  dmem_responder #(
    .DEPTH  (256),
    .LATENCY(2)
  ) dut (
    .CLK      (CLK),
    .resetl   (resetl),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy)
  );

  dmem_responder #(
    .DEPTH  (256),
    .LATENCY(1)
  ) dut1 (
    .CLK      (CLK),
    .resetl   (resetl),
    .req_valid(v1),
    .req_write(w1),
    .req_addr (a1),
    .req_wdata(d1),
    .req_ready(ready1),
    .rsp_valid(rvalid1),
    .rsp_rdata(rdata1),
    .rsp_err  (err1),
    .busy     (busy1)
  );

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    return 64'hA5A5_0000_5A5A_0000 + 64'(i) * 64'h0000_0101_0000_0001;
  endfunction

  // One isolated access on the LATENCY=2 instance, starting from IDLE.
  task automatic access(input string tag, input logic wr, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] exp_rdata,
                        input logic exp_err);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    chk1({tag, " access rsp_valid"}, rsp_valid, 1'b0);
    chk1({tag, " access busy"}, busy, 1'b1);
    chk1({tag, " access req_ready"}, req_ready, 1'b0);
    tick();
    chk1({tag, " respond rsp_valid"}, rsp_valid, 1'b1);
    chk1({tag, " respond rsp_err"}, rsp_err, exp_err);
    chk({tag, " respond rsp_rdata"}, rsp_rdata, exp_rdata);
    tick();
    chk1({tag, " idle rsp_valid"}, rsp_valid, 1'b0);
  endtask

  initial begin
    resetl    = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    v1 = 1'b0;
    w1 = 1'b0;
    a1 = '0;
    d1 = '0;

    // Reset state
    tick();
    tick();
    chk1("reset rsp_valid", rsp_valid, 1'b0);
    chk1("reset rsp_err", rsp_err, 1'b0);
    chk("reset rsp_rdata", rsp_rdata, 64'd0);
    chk1("reset req_ready", req_ready, 1'b0);
    chk1("reset busy", busy, 1'b0);
    chk1("reset l1 rsp_valid", rvalid1, 1'b0);
    chk("reset l1 rsp_rdata", rdata1, 64'd0);

    // Requests during reset are refused
    req_valid = 1'b1;
    tick();
    chk1("reset refuse ready", req_ready, 1'b0);
    chk1("reset refuse busy", busy, 1'b1);
    chk1("reset refuse rsp_valid", rsp_valid, 1'b0);
    req_valid = 1'b0;
    resetl    = 1'b0;
    tick();
    chk1("post reset ready", req_ready, 1'b1);
    chk1("post reset busy", busy, 1'b0);
    chk1("post reset rsp_valid", rsp_valid, 1'b0);

    // Preload the whole array through ordinary stores
    for (int i = 0; i < 256; i++) begin
      model[i] = pat(i);
      access("preload", 1'b1, 64'(i) << 3, model[i], 64'd0, 1'b0);
    end

    // Aligned store then load
    model[2] = 64'hDEAD_BEEF_CAFE_F00D;
    access("store 0x10", 1'b1, 64'h10, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, 1'b0);
    access("load 0x10", 1'b0, 64'h10, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    access("load 0x18", 1'b0, 64'h18, 64'd0, model[3], 1'b0);

    // Misaligned load faults, memory untouched
    access("load 0x13", 1'b0, 64'h13, 64'd0, 64'd0, 1'b1);
    access("reload 0x10", 1'b0, 64'h10, 64'd0, model[2], 1'b0);

    // Out-of-range store faults and commits nothing
    access("store 0x800", 1'b1, 64'h800, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    access("store hi bit", 1'b1, 64'h8000_0000_0000_0008, 64'h1234, 64'd0, 1'b1);
    access("store misalign", 1'b1, 64'h2C, 64'h5555, 64'd0, 1'b1);
    for (int i = 0; i < 256; i++) begin
      chk($sformatf("array word %0d", i), dut.u_array.mem_q[i], model[i]);
    end

    // Back-to-back loads with req_valid held high
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 64'h0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1($sformatf("b2b %0d access busy", k), busy, 1'b1);
      chk1($sformatf("b2b %0d access rsp_valid", k), rsp_valid, 1'b0);
      tick();
      chk1($sformatf("b2b %0d rsp_valid", k), rsp_valid, 1'b1);
      chk($sformatf("b2b %0d rsp_rdata", k), rsp_rdata, model[k]);
      chk1($sformatf("b2b %0d respond ready", k), req_ready, 1'b1);
      chk1($sformatf("b2b %0d respond busy", k), busy, 1'b0);
      req_addr = 64'(k + 1) << 3;
    end
    req_valid = 1'b0;
    tick();
    chk1("b2b end rsp_valid", rsp_valid, 1'b0);
    chk1("b2b end busy", busy, 1'b0);

    // Reset during ACCESS aborts the store
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 64'h20;
    req_wdata = 64'h1111_2222_3333_4444;
    tick();
    chk1("abort access busy", busy, 1'b1);
    req_valid = 1'b0;
    resetl    = 1'b1;
    tick();
    chk1("abort rsp_valid", rsp_valid, 1'b0);
    chk1("abort ready in reset", req_ready, 1'b0);
    resetl = 1'b0;
    #1;
    chk1("abort ready after reset", req_ready, 1'b1);
    tick();
    chk1("abort no late rsp", rsp_valid, 1'b0);
    chk("abort mem[4]", dut.u_array.mem_q[4], model[4]);
    access("abort reload 0x20", 1'b0, 64'h20, 64'd0, model[4], 1'b0);

    // LATENCY=1 instance: response on the accepting edge's next cycle, never busy
    v1 = 1'b1;
    w1 = 1'b1;
    a1 = 64'h8;
    d1 = 64'h0123_4567_89AB_CDEF;
    #1;
    chk1("l1 store busy pre", busy1, 1'b0);
    tick();
    chk1("l1 store rsp_valid", rvalid1, 1'b1);
    chk1("l1 store rsp_err", err1, 1'b0);
    chk("l1 store rsp_rdata", rdata1, 64'd0);
    chk1("l1 store busy", busy1, 1'b0);
    v1 = 1'b0;
    tick();
    chk1("l1 idle rsp_valid", rvalid1, 1'b0);
    chk1("l1 idle busy", busy1, 1'b0);
    v1 = 1'b1;
    w1 = 1'b0;
    #1;
    chk1("l1 load busy pre", busy1, 1'b0);
    tick();
    chk1("l1 load rsp_valid", rvalid1, 1'b1);
    chk("l1 load rsp_rdata", rdata1, 64'h0123_4567_89AB_CDEF);
    chk1("l1 load busy", busy1, 1'b0);
    a1 = 64'h9;
    tick();
    chk1("l1 misalign rsp_valid", rvalid1, 1'b1);
    chk1("l1 misalign rsp_err", err1, 1'b1);
    chk("l1 misalign rsp_rdata", rdata1, 64'd0);
    v1 = 1'b0;
    tick();
    chk1("l1 end rsp_valid", rvalid1, 1'b0);
    chk1("l1 end busy", busy1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
